sdp_ram_reader: RTL and testbench
=================================

Name: sdp_ram_reader

Overview:
- Read-side engine for the 72-bit x 4096 simple-dual-port URAM.
- On a start command it sweeps port B over a contiguous, wrap-around address range and absorbs the fixed RAM read latency.
- Read words go out as a valid/ready stream with full backpressure, through a credit-controlled output FIFO.
- Sits between sdp_ram_top's port B and any downstream consumer; it pairs with the existing port-A write path.

Parameters:
- DATA_WIDTH, 72, RAM word width; in parity mode this is 8 lanes of 9 bits.
- DATA_DEPTH, 4096, RAM depth in words; must be a power of two.
- ADDR_WIDTH, $clog2(DATA_DEPTH) = 12, port B address width.
- RD_LATENCY, 2, cycles from enb sampled high to doutb valid; legal range 1..4.
- FIFO_DEPTH, 4, output FIFO entries; must be >= RD_LATENCY+2.

Ports:
- clk  in  1  single clock for the whole block.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  command strobe; sampled only in IDLE.
- base_addr  in  ADDR_WIDTH  first address to read; sampled with start.
- len  in  ADDR_WIDTH+1  word count, 0..DATA_DEPTH; sampled with start.
- busy  out  1  high from the cycle after an accepted start until the cycle done is high, inclusive.
- done  out  1  one-cycle pulse when a command completes.
- enb  out  1  RAM port B read enable.
- addrb  out  ADDR_WIDTH  RAM port B address.
- doutb  in  DATA_WIDTH  RAM port B read data.
- m_valid  out  1  output stream valid.
- m_data  out  DATA_WIDTH  output stream data.
- m_last  out  1  marks the final word of a command; qualified by m_valid.
- m_ready  in  1  downstream ready.
- par_err  out  1  sticky parity error flag (see Optional Feature).

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - FSM goes to IDLE; FIFO, credit pipeline and counters clear.
  - busy, done, enb, m_valid, m_last and par_err are 0; addrb and m_data are 0.
- FSM states:
  - IDLE: start=1 with len>0 latches base/len and moves to READ. start=1 with len=0 pulses done in the next cycle and stays IDLE; no enb.
  - READ: issues reads. Moves to DRAIN in the cycle the last read issues.
  - DRAIN: waits until the pipeline is empty and the last word has handshaken. Pulses done in the following cycle and returns to IDLE.
- Read issue:
  - enb=1 when in READ, remaining>0 and fifo_count + inflight < FIFO_DEPTH.
  - Each issue increments addrb modulo DATA_DEPTH (4095 -> 0) and decrements remaining.
  - enb is never high outside READ.
- Latency and capture:
  - An enb high in cycle c pushes a token through a RD_LATENCY-deep valid shift register.
  - The token's doutb is written into the FIFO at the end of cycle c+RD_LATENCY.
  - The word appears on m_data with m_valid in cycle c+RD_LATENCY+1.
  - With start high in cycle 0 and default parameters: enb in cycle 1, first m_valid in cycle 4.
- Throughput: with m_ready held at 1, one word per cycle sustained; this is guaranteed by FIFO_DEPTH >= RD_LATENCY+2.
- Credits: inflight is the count of tokens in the shift register. FIFO overflow must be impossible by construction; assert it in simulation.
- Stream rules:
  - A word transfers when m_valid && m_ready.
  - m_data and m_last stay stable while m_valid && !m_ready.
  - Words come out in address order.
  - m_last=1 only on word number len.
- Simultaneous events:
  - FIFO push and pop in the same cycle leave the count unchanged.
  - start while busy is ignored; no queuing.
- len = DATA_DEPTH reads every address once, starting at base_addr and wrapping.
- Reset mid-command abandons it: no done, and stale words are discarded.

Optional Feature:
- Macro: SDP_RD_PARITY_EN.
- Defined:
  - Each word is 8 lanes. Byte i is data[8i+7:8i]; its even-parity bit is data[64+i].
  - The parity check is on the FIFO output word at handshake.
  - Any mismatch sets par_err; par_err clears only on an accepted start or on reset.
  - m_data still carries the full 72 bits.
- Undefined: par_err is tied to 0 and no check logic is built.

Decomposition:
- Package sdp_ram_pkg: DATA_WIDTH/DATA_DEPTH defaults, ADDR_WIDTH derivation, FSM state enum {IDLE, READ, DRAIN}, and the parity lane constants (8 lanes, 8 data bits per lane, parity base bit 64).
- Sub-module sdp_rd_fifo: synchronous FIFO with count output, parameterised on width and depth. Its push comes from the latency pipeline tail and its pop from the stream handshake.

Test Plan:
- base=0, len=8, m_ready=1, RAM preloaded with mem[a]=a:
  - enb in cycles 1..8.
  - m_data 0..7 in cycles 4..11; m_last in cycle 11.
  - done in cycle 12; busy deasserted in cycle 13.
- base=4094, len=4: addrb sequence 4094, 4095, 0, 1; output order matches.
- base=0, len=16, m_ready toggled 1-of-3 cycles:
  - no word lost or duplicated; data holds stable while stalled.
  - enb stalls once fifo_count + inflight = 4.
- start with len=0: done pulses the next cycle; enb never asserts; busy stays 0.
- rst_n dropped mid-command after 5 words; then start base=100, len=2: only words 100 and 101 appear; no done from the aborted command.
- SDP_RD_PARITY_EN with mem[3] bit 64 flipped, len=6: par_err rises at word 3's handshake and stays 1 until the next start.

Source files
------------

// File: rtl/sdp_ram_pkg.sv
// Shared constants and types for the simple-dual-port RAM read engine.
// Holds default geometry, the read FSM state type and the parity lane layout.
// Parity helpers are only used when SDP_RD_PARITY_EN is defined.
package sdp_ram_pkg;

    localparam int DATA_WIDTH_DEF = 72;
    localparam int DATA_DEPTH_DEF = 4096;
    localparam int ADDR_WIDTH_DEF = $clog2(DATA_DEPTH_DEF);

    // Parity mode: 8 byte lanes, lane i parity bit lives at PAR_BASE + i
    localparam int PAR_LANES     = 8;
    localparam int PAR_LANE_BITS = 8;
    localparam int PAR_BASE      = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } rd_state_t;

endpackage

// File: rtl/sdp_rd_fifo.sv
// Generic synchronous FIFO with occupancy count, no reset on the storage array.
// Latency: a word pushed in cycle c is visible on pop_dat/vld in cycle c+1.
// Backpressure: none internally; the writer must guarantee room (checked by assertion).
module sdp_rd_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_dat,
    output logic             vld,
    output logic [CW-1:0]    count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;

    // Pointer advance with explicit wrap so non-power-of-two depths work
    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Storage write; contents need no reset because count gates visibility
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    // Pointer and occupancy tracking; simultaneous push and pop keep count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= bump(wr_ptr);
            if (pop)  rd_ptr <= bump(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign pop_dat = mem[rd_ptr];
    assign vld     = (count != '0);

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && !pop && (count == CW'(DEPTH))));

    a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(pop && (count == '0)));

endmodule

// File: rtl/sdp_ram_reader.sv
// Read-side engine: sweeps RAM port B over a wrap-around range and streams the words out.
// Latency: start in cycle 0 -> enb in cycle 1 -> first m_valid in cycle 2+RD_LATENCY.
// Backpressure: full valid/ready; reads issue only while fifo_count+inflight < FIFO_DEPTH.
// Optional: define SDP_RD_PARITY_EN to build the per-lane even-parity check driving par_err.
module sdp_ram_reader
    import sdp_ram_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int DATA_DEPTH = DATA_DEPTH_DEF,
    parameter int ADDR_WIDTH = $clog2(DATA_DEPTH),
    parameter int RD_LATENCY = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   len,
    output logic                  busy,
    output logic                  done,
    output logic                  enb,
    output logic [ADDR_WIDTH-1:0] addrb,
    input  logic [DATA_WIDTH-1:0] doutb,
    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    input  logic                  m_ready,
    output logic                  par_err
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int IW = $clog2(RD_LATENCY + 1);
    localparam int SW = CW + IW;
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH:0]   REM_ONE  = (ADDR_WIDTH + 1)'(1);

    rd_state_t             state;
    rd_state_t             state_nxt;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [ADDR_WIDTH:0]   rem_q;
    logic [RD_LATENCY-1:0] vld_sr;
    logic [RD_LATENCY-1:0] last_sr;
    logic [IW-1:0]         inflight;
    logic [CW-1:0]         fifo_count;
    logic                  credit_ok;
    logic                  last_issue;
    logic                  accept;
    logic                  done_set;
    logic                  drain_ok;
    logic                  pop;
    logic                  fifo_vld;
    logic [DATA_WIDTH:0]   fifo_dout;

    // Tokens currently travelling through the RAM latency pipeline
    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LATENCY; i++) begin
            inflight = inflight + IW'(vld_sr[i]);
        end
    end

    // Every issued read is guaranteed a FIFO slot before it is launched
    assign credit_ok  = (SW'(fifo_count) + SW'(inflight)) < SW'(FIFO_DEPTH);
    assign enb        = (state == READ) && (rem_q != '0) && credit_ok;
    assign last_issue = enb && (rem_q == REM_ONE);
    assign addrb      = addr_q;
    assign pop        = fifo_vld && m_ready;

    // Only the final word can remain once the pipeline is empty in DRAIN
    assign drain_ok = (inflight == '0) &&
                      ((fifo_count == '0) || ((fifo_count == CW'(1)) && pop));

    // Next-state and command-level strobes
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        done_set  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (len != '0) begin
                        accept    = 1'b1;
                        state_nxt = READ;
                    end else begin
                        done_set = 1'b1;
                    end
                end
            end
            READ: begin
                if (last_issue) state_nxt = DRAIN;
            end
            DRAIN: begin
                if (drain_ok) begin
                    done_set  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register plus busy/done; busy covers the done cycle of a real command
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            busy  <= (state_nxt != IDLE) || ((state == DRAIN) && drain_ok);
            done  <= done_set;
        end
    end

    // Address walks modulo depth; remaining counts down per issued read
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q <= '0;
            rem_q  <= '0;
        end else if (accept) begin
            addr_q <= base_addr;
            rem_q  <= len;
        end else if (enb) begin
            addr_q <= addr_q + ADDR_ONE;
            rem_q  <= rem_q - REM_ONE;
        end
    end

    // Valid/last token pipeline matching the fixed RAM read latency
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_sr  <= '0;
            last_sr <= '0;
        end else begin
            vld_sr[0]  <= enb;
            last_sr[0] <= last_issue;
            for (int i = 1; i < RD_LATENCY; i++) begin
                vld_sr[i]  <= vld_sr[i-1];
                last_sr[i] <= last_sr[i-1];
            end
        end
    end

    sdp_rd_fifo #(
        .WIDTH (DATA_WIDTH + 1),
        .DEPTH (FIFO_DEPTH),
        .CW    (CW)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (vld_sr[RD_LATENCY-1]),
        .push_dat ({last_sr[RD_LATENCY-1], doutb}),
        .pop      (pop),
        .pop_dat  (fifo_dout),
        .vld      (fifo_vld),
        .count    (fifo_count)
    );

    // Output is forced to zero while empty so reset and idle show a clean bus
    assign m_valid = fifo_vld;
    assign m_data  = fifo_vld ? fifo_dout[DATA_WIDTH-1:0] : '0;
    assign m_last  = fifo_vld && fifo_dout[DATA_WIDTH];

`ifdef SDP_RD_PARITY_EN
    logic par_bad;
    logic par_err_q;

    // Any byte lane whose 9 bits hold odd parity is a mismatch
    always_comb begin
        par_bad = 1'b0;
        for (int i = 0; i < PAR_LANES; i++) begin
            par_bad = par_bad |
                      (^{m_data[PAR_BASE+i], m_data[i*PAR_LANE_BITS +: PAR_LANE_BITS]});
        end
    end

    // Sticky error, cleared by a new command
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_err_q <= 1'b0;
        end else if (accept) begin
            par_err_q <= 1'b0;
        end else if (pop && par_bad) begin
            par_err_q <= 1'b1;
        end
    end

    assign par_err = par_err_q;
`else
    assign par_err = 1'b0;
`endif

endmodule

// File: tb/tb_sdp_ram_reader.sv
module tb_sdp_ram_reader;

    localparam int DW  = 72;
    localparam int DD  = 4096;
    localparam int AW  = 12;
    localparam int LAT = 2;
    localparam int FD  = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW:0]   len = '0;
    logic          busy, done, enb;
    logic [AW-1:0] addrb;
    logic [DW-1:0] doutb;
    logic          m_valid;
    logic [DW-1:0] m_data;
    logic          m_last;
    logic          m_ready = 1'b1;
    logic          par_err;

    always #5 clk = ~clk;

    sdp_ram_reader dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .base_addr (base_addr),
        .len       (len),
        .busy      (busy),
        .done      (done),
        .enb       (enb),
        .addrb     (addrb),
        .doutb     (doutb),
        .m_valid   (m_valid),
        .m_data    (m_data),
        .m_last    (m_last),
        .m_ready   (m_ready),
        .par_err   (par_err)
    );

    // RAM model: port B with fixed two-cycle read latency
    logic [DW-1:0] mem [DD];
    logic [DW-1:0] rd_pipe [LAT];
    always @(posedge clk) begin
        if (enb) rd_pipe[0] <= mem[addrb];
        for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign doutb = rd_pipe[LAT-1];

    // Reference model state
    int            vec_cnt = 0;
    int            miscompares = 0;
    int            cyc_n = 0;
    int            rmode = 0;
    logic [DW-1:0] exp_q [$];
    int            exp_addr, issued, popped, max_out, done_cnt, t0;
    int            first_enb, last_enb, first_vld, last_cyc, done_cyc;
    logic          busy_at_done, busy_after, busy_seen;
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data;
    logic          prev_last;
    logic          exp_par = 1'b0;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        vec_cnt++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] mk_word(input logic [63:0] d);
        logic [7:0] p;
        for (int i = 0; i < 8; i++) p[i] = ^d[8*i +: 8];
        return {p, d};
    endfunction

    function automatic logic bad_par(input logic [DW-1:0] w);
        for (int i = 0; i < 8; i++) if (^{w[64+i], w[8*i +: 8]}) return 1'b1;
        return 1'b0;
    endfunction

    task automatic check_cycle();
        int            outstanding;
        logic [DW-1:0] w;
        outstanding = issued - popped;
        if (prev_stall) begin
            chk("hold_valid", m_valid, 1);
            chk("hold_data", m_data, prev_data);
            chk("hold_last", m_last, prev_last);
        end
        if (outstanding >= FD) chk("credit_stall", enb, 0);
        if (outstanding > max_out) max_out = outstanding;
        if (enb) begin
            chk("enb_busy", busy, 1);
            chk("addrb", addrb, exp_addr);
            if (first_enb < 0) first_enb = cyc_n;
            last_enb = cyc_n;
            exp_addr = (exp_addr + 1) % DD;
            issued++;
        end
        chk("par_err", par_err, exp_par);
        if (m_valid && first_vld < 0) first_vld = cyc_n;
        if (m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
                chk("extra_word", m_valid, 0);
            end else begin
                w = exp_q.pop_front();
                chk("m_data", m_data, w);
                chk("m_last", m_last, exp_q.size() == 0);
                if (m_last) last_cyc = cyc_n;
                popped++;
`ifdef SDP_RD_PARITY_EN
                if (bad_par(w)) exp_par = 1'b1;
`endif
            end
        end
        if (done_cyc >= 0 && cyc_n == done_cyc + 1) busy_after = busy;
        if (done) begin
            done_cnt++;
            done_cyc = cyc_n;
            busy_at_done = busy;
        end
        if (busy) busy_seen = 1'b1;
        prev_stall = m_valid && !m_ready;
        prev_data  = m_data;
        prev_last  = m_last;
    endtask

    task automatic cyc();
        case (rmode)
            0:       m_ready = 1'b1;
            1:       m_ready = (cyc_n % 3 == 0);
            default: m_ready = 1'($urandom_range(0, 1));
        endcase
        @(negedge clk);
        check_cycle();
        @(posedge clk);
        #1;
        cyc_n++;
    endtask

    task automatic start_cmd(input int b, input int l, input int mode);
        rmode = mode;
        exp_q.delete();
        for (int i = 0; i < l; i++) exp_q.push_back(mem[(b + i) % DD]);
        exp_addr = b; issued = 0; popped = 0; max_out = 0; done_cnt = 0;
        first_enb = -1; last_enb = -1; first_vld = -1; last_cyc = -1; done_cyc = -1;
        busy_at_done = 1'b0; busy_after = 1'b1; busy_seen = 1'b0;
        t0 = cyc_n;
        base_addr = AW'(b);
        len = (AW + 1)'(l);
        start = 1'b1;
        cyc();
        start = 1'b0;
        if (l > 0) exp_par = 1'b0;
    endtask

    task automatic finish_cmd(input int budget);
        int n = 0;
        while (done_cnt == 0 && n < budget) begin
            cyc();
            n++;
        end
        if (done_cnt == 0) chk("done_timeout", done, 1);
        cyc();
        chk("drained", exp_q.size(), 0);
        chk("done_once", done_cnt, 1);
    endtask

    initial begin
        int n;
        int b, l;
        rst_n = 1'b1;
        for (int i = 0; i < DD; i++) mem[i] = mk_word({$urandom, $urandom});
        for (int i = 0; i < LAT; i++) rd_pipe[i] = '0;
        #1 rst_n = 1'b0;
        #2;
        chk("rst_busy", busy, 0);      chk("rst_done", done, 0);
        chk("rst_enb", enb, 0);        chk("rst_addrb", addrb, 0);
        chk("rst_m_valid", m_valid, 0); chk("rst_m_data", m_data, 0);
        chk("rst_m_last", m_last, 0);  chk("rst_par_err", par_err, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Directed: base 0, len 8, identity data, ready held high
        for (int a = 0; a < 8; a++) mem[a] = mk_word(64'(a));
        start_cmd(0, 8, 0);
        finish_cmd(60);
        chk("t1_first_enb", first_enb - t0, 1);
        chk("t1_last_enb", last_enb - t0, 8);
        chk("t1_enb_count", issued, 8);
        chk("t1_first_valid", first_vld - t0, 4);
        chk("t1_last_cycle", last_cyc - t0, 11);
        chk("t1_done_cycle", done_cyc - t0, 12);
        chk("t1_busy_at_done", busy_at_done, 1);
        chk("t1_busy_after", busy_after, 0);

        // Wrap across the top of the address space
        start_cmd(4094, 4, 0);
        finish_cmd(60);
        chk("t2_issued", issued, 4);

        // Sparse ready forces the credit limit
        start_cmd(0, 16, 1);
        finish_cmd(200);
        chk("t3_credit_full", max_out, FD);

        // Zero-length command
        start_cmd(300, 0, 0);
        finish_cmd(10);
        chk("t4_done_cycle", done_cyc - t0, 1);
        chk("t4_no_enb", issued, 0);
        chk("t4_no_busy", busy_seen, 0);

        // Corrupted parity on the fourth word
        mem[23][64] = ~mem[23][64];
        start_cmd(20, 6, 0);
        finish_cmd(60);
`ifdef SDP_RD_PARITY_EN
        chk("t5_par_sticky", par_err, 1);
`else
        chk("t5_par_tied", par_err, 0);
`endif
        start_cmd(200, 3, 2);
        finish_cmd(60);
        chk("t5_par_cleared", par_err, 0);

        // Reset in the middle of a command
        start_cmd(0, 16, 0);
        n = 0;
        while (popped < 5 && n < 50) begin
            cyc();
            n++;
        end
        chk("t6_five_words", popped, 5);
        rst_n = 1'b0;
        exp_q.delete(); issued = 0; popped = 0; prev_stall = 1'b0; exp_par = 1'b0;
        #1;
        chk("t6_rst_valid", m_valid, 0);
        chk("t6_rst_enb", enb, 0);
        chk("t6_rst_busy", busy, 0);
        cyc();
        rst_n = 1'b1;
        cyc();
        cyc();
        chk("t6_no_done", done_cnt, 0);
        start_cmd(100, 2, 0);
        finish_cmd(40);
        chk("t6_words", popped, 2);

        // Random commands with random backpressure
        for (int k = 0; k < 4; k++) begin
            b = $urandom_range(0, DD - 1);
            l = $urandom_range(1, 40);
            start_cmd(b, l, 2);
            finish_cmd(l * 8 + 40);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompares);
        $finish;
    end

endmodule
